commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_pkg.sv | 33 +++
 rtl/commit_trace_mwfifo.sv | 49 ++++
 rtl/commit_trace_buffer.sv | 114 +++++++++++
 tb/tb_commit_trace_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared commit-trace record types and widths.
// Fields of commit_trace_t mirror the cosim commit-info record.
// Optional feature macro: COMMIT_TRACE_XCPT_EN adds exception fields to FIFO storage.
package commit_trace_pkg;
    localparam int COMMIT_LANES = 2;
    localparam int XLEN         = 64;
    localparam int INS_W        = 32;
    localparam int REG_W        = 5;

    typedef struct packed {
        logic [XLEN-1:0]  hart_id;
        logic [XLEN-1:0]  pc;
        logic [INS_W-1:0] ins;
        logic [REG_W-1:0] dst;
        logic             wr_valid;
        logic [XLEN-1:0]  data;
        logic             xcpt;
        logic [XLEN-1:0]  xcpt_cause;
    } commit_trace_t;

    // Stored FIFO payload; hart_id is a constant and never stored.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [INS_W-1:0] ins;
        logic [REG_W-1:0] dst;
        logic             wr_valid;
        logic [XLEN-1:0]  data;
`ifdef COMMIT_TRACE_XCPT_EN
        logic             xcpt;
        logic [XLEN-1:0]  xcpt_cause;
`endif
    } trace_entry_t;
endpackage

// File: rtl/commit_trace_mwfifo.sv
// commit_trace_mwfifo: FIFO with two write ports (port 1 lands after port 0) and one read port.
// Ports: clk, rst_n (async active-low); i_we0/i_wd0, i_we1/i_wd1 write ports (i_we1 only with i_we0);
//        i_re dequeue strobe; o_rd head entry (registered storage); o_count occupancy.
module commit_trace_mwfifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we0,
    input  logic                     i_we1,
    input  trace_entry_t             i_wd0,
    input  trace_entry_t             i_wd1,
    input  logic                     i_re,
    output trace_entry_t             o_rd,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  w_wptr1;

    // Natural AW-bit wrap places a lane-1 write at index 0 when r_wptr is DEPTH-1.
    assign w_wptr1 = r_wptr + AW'(1);
    assign o_rd    = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + AW'(i_we0) + AW'(i_we1);
            r_rptr  <= r_rptr + AW'(i_re);
            r_count <= r_count + CW'(i_we0) + CW'(i_we1) - CW'(i_re);
        end
    end

    always_ff @(posedge clk) begin
        if (i_we0) r_mem[r_wptr]  <= i_wd0;
        if (i_we1) r_mem[w_wptr1] <= i_wd1;
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: non-stalling commit trace FIFO between a 2-wide core and a cosim checker.
// Ports: clk, rst_n (async active-low); commit_*_i per-lane retire info (lane 0 older);
//        trace_valid_o/trace_ready_i/trace_o head handshake; trace_seq_o head index since reset;
//        count_o occupancy; overflow_o sticky drop flag.
// Macro: COMMIT_TRACE_XCPT_EN stores and presents xcpt/xcpt_cause; otherwise those fields read 0.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int HART_ID = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [COMMIT_LANES-1:0]                 commit_valid_i,
    input  logic [COMMIT_LANES-1:0][XLEN-1:0]       commit_pc_i,
    input  logic [COMMIT_LANES-1:0][INS_W-1:0]      commit_ins_i,
    input  logic [COMMIT_LANES-1:0][REG_W-1:0]      commit_dst_i,
    input  logic [COMMIT_LANES-1:0]                 commit_wr_valid_i,
    input  logic [COMMIT_LANES-1:0][XLEN-1:0]       commit_data_i,
    input  logic [COMMIT_LANES-1:0]                 commit_xcpt_i,
    input  logic [COMMIT_LANES-1:0][XLEN-1:0]       commit_xcpt_cause_i,
    output logic                                    trace_valid_o,
    input  logic                                    trace_ready_i,
    output commit_trace_t                           trace_o,
    output logic [63:0]                             trace_seq_o,
    output logic [$clog2(DEPTH):0]                  count_o,
    output logic                                    overflow_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    trace_entry_t   w_lane [COMMIT_LANES];
    trace_entry_t   w_wd0;
    trace_entry_t   w_rd;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_free;
    logic [1:0]     w_nv;
    logic           w_we0;
    logic           w_we1;
    logic           w_deq;
    logic           w_drop;
    logic [63:0]    r_seq;
    logic           r_overflow;

    always_comb begin
        for (int l = 0; l < COMMIT_LANES; l++) begin
            w_lane[l]          = '0;
            w_lane[l].pc       = commit_pc_i[l];
            w_lane[l].ins      = commit_ins_i[l];
            w_lane[l].dst      = commit_dst_i[l];
            w_lane[l].wr_valid = commit_wr_valid_i[l];
            w_lane[l].data     = commit_data_i[l];
`ifdef COMMIT_TRACE_XCPT_EN
            w_lane[l].xcpt       = commit_xcpt_i[l];
            w_lane[l].xcpt_cause = commit_xcpt_cause_i[l];
`endif
        end
    end

`ifndef COMMIT_TRACE_XCPT_EN
    logic w_xcpt_unused;
    assign w_xcpt_unused = ^{commit_xcpt_i, commit_xcpt_cause_i};
`endif

    // Free space uses start-of-cycle occupancy, so a same-cycle dequeue never makes room.
    assign w_nv   = {1'b0, commit_valid_i[0]} + {1'b0, commit_valid_i[1]};
    assign w_free = CW'(DEPTH) - w_count;
    assign w_we0  = (w_nv != 2'd0) && (w_free != '0);
    assign w_we1  = (w_nv == 2'd2) && (w_free >= CW'(2));
    assign w_drop = CW'(w_nv) > w_free;
    // A lone lane-1 commit is compacted onto write port 0.
    assign w_wd0  = commit_valid_i[0] ? w_lane[0] : w_lane[1];

    assign trace_valid_o = w_count != '0;
    assign w_deq         = trace_valid_o && trace_ready_i;
    assign count_o       = w_count;
    assign trace_seq_o   = r_seq;
    assign overflow_o    = r_overflow;

    commit_trace_mwfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we0   (w_we0),
        .i_we1   (w_we1),
        .i_wd0   (w_wd0),
        .i_wd1   (w_lane[1]),
        .i_re    (w_deq),
        .o_rd    (w_rd),
        .o_count (w_count)
    );

    always_comb begin
        trace_o          = '0;
        trace_o.hart_id  = XLEN'(HART_ID);
        trace_o.pc       = w_rd.pc;
        trace_o.ins      = w_rd.ins;
        trace_o.dst      = w_rd.dst;
        trace_o.wr_valid = w_rd.wr_valid;
        trace_o.data     = w_rd.data;
`ifdef COMMIT_TRACE_XCPT_EN
        trace_o.xcpt       = w_rd.xcpt;
        trace_o.xcpt_cause = w_rd.xcpt_cause;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_seq      <= r_seq + 64'(w_deq);
            r_overflow <= r_overflow | w_drop;
        end
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: table vectors, directed corner sequences and a queue-model random run.
module tb_commit_trace_buffer;
    import commit_trace_pkg::*;

    localparam int DEPTH = 8;

    logic                               clk = 1'b0;
    logic                               rst_n = 1'b0;
    logic [1:0]                         commit_valid_i = '0;
    logic [1:0][63:0]                   commit_pc_i = '0;
    logic [1:0][31:0]                   commit_ins_i = '0;
    logic [1:0][4:0]                    commit_dst_i = '0;
    logic [1:0]                         commit_wr_valid_i = '0;
    logic [1:0][63:0]                   commit_data_i = '0;
    logic [1:0]                         commit_xcpt_i = '0;
    logic [1:0][63:0]                   commit_xcpt_cause_i = '0;
    logic                               trace_valid_o;
    logic                               trace_ready_i = 1'b0;
    commit_trace_t                      trace_o;
    logic [63:0]                        trace_seq_o;
    logic [$clog2(DEPTH):0]             count_o;
    logic                               overflow_o;

    commit_trace_buffer #(.DEPTH(DEPTH), .HART_ID(0)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .commit_valid_i      (commit_valid_i),
        .commit_pc_i         (commit_pc_i),
        .commit_ins_i        (commit_ins_i),
        .commit_dst_i        (commit_dst_i),
        .commit_wr_valid_i   (commit_wr_valid_i),
        .commit_data_i       (commit_data_i),
        .commit_xcpt_i       (commit_xcpt_i),
        .commit_xcpt_cause_i (commit_xcpt_cause_i),
        .trace_valid_o       (trace_valid_o),
        .trace_ready_i       (trace_ready_i),
        .trace_o             (trace_o),
        .trace_seq_o         (trace_seq_o),
        .count_o             (count_o),
        .overflow_o          (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic [4:0]  dst;
        logic        wr;
        logic [63:0] data;
        logic        xc;
        logic [63:0] cause;
    } mentry_t;

    typedef struct {
        logic [1:0]  v;
        logic        rdy;
        logic [63:0] pc0;
        logic [63:0] pc1;
        int          cnt;
        logic [63:0] pc;
        logic [63:0] seq;
    } vec_t;

    mentry_t     q[$];
    logic [63:0] m_seq;
    logic        m_ovf;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mentry_t mk(input logic [63:0] pc);
        mentry_t m;
        m.pc    = pc;
        m.ins   = pc[31:0] ^ 32'h0000_0013;
        m.dst   = pc[6:2];
        m.wr    = pc[2];
        m.data  = ~pc;
        m.xc    = pc[3];
        m.cause = pc >> 4;
        return m;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        commit_valid_i = '0;
        trace_ready_i = 1'b0;
        q.delete();
        m_seq = '0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one cycle, advances the reference queue model, then samples 1 time unit after the edge.
    task automatic step(input logic [1:0] v, input logic rdy, input mentry_t e0, input mentry_t e1);
        mentry_t lanes[$];
        int free;
        commit_valid_i = v;
        trace_ready_i = rdy;
        commit_pc_i[0] = e0.pc;     commit_pc_i[1] = e1.pc;
        commit_ins_i[0] = e0.ins;   commit_ins_i[1] = e1.ins;
        commit_dst_i[0] = e0.dst;   commit_dst_i[1] = e1.dst;
        commit_wr_valid_i = {e1.wr, e0.wr};
        commit_data_i[0] = e0.data; commit_data_i[1] = e1.data;
        commit_xcpt_i = {e1.xc, e0.xc};
        commit_xcpt_cause_i[0] = e0.cause; commit_xcpt_cause_i[1] = e1.cause;
        free = DEPTH - q.size();
        if (v[0]) lanes.push_back(e0);
        if (v[1]) lanes.push_back(e1);
        if (q.size() > 0 && rdy) begin
            void'(q.pop_front());
            m_seq++;
        end
        foreach (lanes[i]) begin
            if (i < free) q.push_back(lanes[i]);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 64'(trace_valid_o), 64'(q.size() > 0));
        chk({tag, ".count"}, 64'(count_o), 64'(q.size()));
        chk({tag, ".seq"}, trace_seq_o, m_seq);
        chk({tag, ".ovf"}, 64'(overflow_o), 64'(m_ovf));
        if (q.size() > 0) begin
            chk({tag, ".hart"}, trace_o.hart_id, 64'd0);
            chk({tag, ".pc"}, trace_o.pc, q[0].pc);
            chk({tag, ".ins"}, 64'(trace_o.ins), 64'(q[0].ins));
            chk({tag, ".dst"}, 64'(trace_o.dst), 64'(q[0].dst));
            chk({tag, ".wr"}, 64'(trace_o.wr_valid), 64'(q[0].wr));
            chk({tag, ".data"}, trace_o.data, q[0].data);
`ifdef COMMIT_TRACE_XCPT_EN
            chk({tag, ".xcpt"}, 64'(trace_o.xcpt), 64'(q[0].xc));
            chk({tag, ".cause"}, trace_o.xcpt_cause, q[0].cause);
`else
            chk({tag, ".xcpt"}, 64'(trace_o.xcpt), 64'd0);
            chk({tag, ".cause"}, trace_o.xcpt_cause, 64'd0);
`endif
        end
    endtask

    vec_t    tbl[6];
    mentry_t nil;
    mentry_t e;

    initial begin
        nil = mk(64'h0);
        tbl[0] = '{2'b11, 1'b0, 64'h100, 64'h104, 2, 64'h100, 64'd0};
        tbl[1] = '{2'b00, 1'b0, 64'h0,   64'h0,   2, 64'h100, 64'd0};
        tbl[2] = '{2'b00, 1'b1, 64'h0,   64'h0,   1, 64'h104, 64'd1};
        tbl[3] = '{2'b00, 1'b1, 64'h0,   64'h0,   0, 64'h0,   64'd2};
        tbl[4] = '{2'b10, 1'b1, 64'h0,   64'h200, 1, 64'h200, 64'd2};
        tbl[5] = '{2'b01, 1'b1, 64'h300, 64'h0,   1, 64'h300, 64'd3};

        do_reset();
        #1;
        chk("reset.valid", 64'(trace_valid_o), 64'd0);
        chk("reset.count", 64'(count_o), 64'd0);
        chk("reset.seq", trace_seq_o, 64'd0);
        chk("reset.ovf", 64'(overflow_o), 64'd0);

        // Single commit: latency 1, first seq 0.
        e = mk(64'h8000_0000);
        e.ins = 32'h0000_0013;
        step(2'b01, 1'b1, e, nil);
        chk("single.valid", 64'(trace_valid_o), 64'd1);
        chk("single.pc", trace_o.pc, 64'h8000_0000);
        chk("single.ins", 64'(trace_o.ins), 64'h13);
        chk("single.seq", trace_seq_o, 64'd0);
        chk("single.count", 64'(count_o), 64'd1);

        // Table vectors: dual commit, hold while not ready, accepts, lane-1-only, simultaneous.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].rdy, mk(tbl[i].pc0), mk(tbl[i].pc1));
            chk($sformatf("tbl%0d.count", i), 64'(count_o), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d.valid", i), 64'(trace_valid_o), 64'(tbl[i].cnt != 0));
            chk($sformatf("tbl%0d.seq", i), trace_seq_o, tbl[i].seq);
            if (tbl[i].cnt != 0) chk($sformatf("tbl%0d.pc", i), trace_o.pc, tbl[i].pc);
        end

        // Overflow: fill to 7, dual commit drops lane 1; flag sticks until reset.
        do_reset();
        for (int i = 0; i < 7; i++) step(2'b01, 1'b0, mk(64'h1000 + 64'(i * 4)), nil);
        chk("ovf.fill7", 64'(count_o), 64'd7);
        step(2'b11, 1'b0, mk(64'h2000), mk(64'h2004));
        chk("ovf.count", 64'(count_o), 64'd8);
        chk("ovf.flag", 64'(overflow_o), 64'd1);
        repeat (8) begin
            step(2'b00, 1'b1, nil, nil);
            check_model("ovf.drain");
        end
        chk("ovf.held", 64'(overflow_o), 64'd1);

        // Full with a same-cycle dequeue: commit still dropped; then count 6 + deq + dual -> 7.
        do_reset();
        for (int i = 0; i < 4; i++) step(2'b11, 1'b0, mk(64'h3000 + 64'(i * 8)), mk(64'h3004 + 64'(i * 8)));
        chk("full.count", 64'(count_o), 64'd8);
        chk("full.noovf", 64'(overflow_o), 64'd0);
        step(2'b01, 1'b1, mk(64'h3100), nil);
        chk("simul.drop.count", 64'(count_o), 64'd7);
        chk("simul.drop.ovf", 64'(overflow_o), 64'd1);
        step(2'b00, 1'b1, nil, nil);
        chk("simul.count6", 64'(count_o), 64'd6);
        step(2'b11, 1'b1, mk(64'h3200), mk(64'h3204));
        chk("simul.count7", 64'(count_o), 64'd7);
        check_model("simul");

        // Wrap: write pointer at 7, dual commit lands at indices 7 and 0.
        do_reset();
        for (int i = 0; i < 7; i++) step(2'b01, 1'b0, mk(64'h4000 + 64'(i * 4)), nil);
        repeat (7) step(2'b00, 1'b1, nil, nil);
        chk("wrap.empty", 64'(count_o), 64'd0);
        step(2'b11, 1'b0, mk(64'h5000), mk(64'h5004));
        chk("wrap.head7", trace_o.pc, 64'h5000);
        step(2'b00, 1'b1, nil, nil);
        chk("wrap.head0", trace_o.pc, 64'h5004);
        check_model("wrap");

        // Asynchronous reset mid-stream, sampled between clock edges.
        rst_n = 1'b0;
        q.delete();
        m_seq = '0;
        m_ovf = 1'b0;
        #1;
        chk("areset.valid", 64'(trace_valid_o), 64'd0);
        chk("areset.seq", trace_seq_o, 64'd0);
        chk("areset.count", 64'(count_o), 64'd0);
        do_reset();

        // Exception fields follow the build configuration.
        e = mk(64'h6000);
        e.xc = 1'b1;
        e.cause = 64'h2;
        step(2'b01, 1'b0, e, nil);
`ifdef COMMIT_TRACE_XCPT_EN
        chk("macro.cause", trace_o.xcpt_cause, 64'h2);
`else
        chk("macro.cause", trace_o.xcpt_cause, 64'h0);
`endif
        check_model("macro");

        // Random run against the queue model; ready bias shifts so the FIFO fills and drains.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (i == 350) do_reset();
            step(2'(($urandom_range(0, 3))), rdy, mk({$urandom, $urandom}), mk({$urandom, $urandom}));
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
